dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ARB_MODE, default 0; 0 = round-robin, 1 = fixed priority with p0 winning.
REQ-002 SHALL have parameter MEM_BYTES, default 64; the byte size of the attached data memory.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have, for each requester x in {p0, p1}, ports px_req_valid in 1, px_req_ready out 1, px_we in 1 (1 = store), px_addr in 64, px_wdata in 64, px_size in 2.
REQ-006 SHALL have, for each requester x, ports px_resp_valid out 1, px_resp_ready in 1, px_rdata out 64, px_err out 1.
REQ-007 SHALL encode size as 00 = byte, 01 = half (2B), 10 = word (4B), 11 = double (8B).
REQ-008 SHALL have memory-side ports mem_addr out 64, mem_wdata out 64, mem_write out 1, mem_read out 1, mem_size out 2, mem_rdata in 64.
REQ-009 SHALL treat mem_rdata as combinational big-endian, sign-extended read data that is valid in the same cycle as mem_read.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, RESP, with one outstanding transaction total.
REQ-011 IDLE: SHALL assert px_req_ready combinationally only for the arbitration winner, and only while that requester's px_req_valid is high; the loser's ready SHALL be 0.
REQ-012 Arbitration: with a single requester valid, that requester wins; with both valid in ARB_MODE=0, the requester favoured by rr_ptr wins; in ARB_MODE=1, p0 wins.
REQ-013 SHALL reset rr_ptr to favour p0, and SHALL move it to favour the other requester after each accepted request.
REQ-014 On handshake (valid & ready) in cycle N, SHALL latch we, addr, wdata, size and the grant id, then enter ACCESS in cycle N+1.
REQ-015 SHALL evaluate the range error at latch time: err = (addr[5:0] + bytes(size) > MEM_BYTES) or (addr[63:6] != 0).
REQ-016 ACCESS, no error: SHALL drive mem_addr, mem_wdata and mem_size from the latched values; mem_write = we; mem_read = !we.
REQ-017 ACCESS, no error: a store SHALL commit at the rising edge ending N+1; a load SHALL capture mem_rdata into the response register at that same edge.
REQ-018 ACCESS, error: SHALL keep mem_write = mem_read = 0 and set the response to rdata = 0, err = 1.
REQ-019 SHALL drive mem_write = mem_read = 0 in every state other than ACCESS.
REQ-020 SHALL enter RESP in N+2 and assert px_resp_valid only for the granted requester.
REQ-021 Store responses SHALL carry rdata = 0, err = 0.
REQ-022 RESP: px_resp_valid, px_rdata and px_err SHALL hold stable until px_resp_ready is high; the FSM SHALL then return to IDLE on the next edge.
REQ-023 No new request SHALL be accepted while in RESP, including the acceptance cycle, so the minimum spacing between accepts is 3 cycles.
REQ-024 Latency: with resp_ready tied high, response valid SHALL be 2 cycles after accept.
REQ-025 SHALL ignore changes to px_addr, px_wdata, px_size and px_we after acceptance.
REQ-026 A non-granted requester SHALL be able to hold valid indefinitely; in ARB_MODE=0, starvation SHALL be bounded to one transaction.

Reset
REQ-027 When rst_n is sampled low, SHALL enter IDLE and set rr_ptr to favour p0.
REQ-028 During reset, all outputs SHALL be 0: req_ready, resp_valid, rdata, err and all mem_* ports.
REQ-029 mem_write and mem_read SHALL be gated by rst_n, so a store in ACCESS does not commit at the edge where rst_n is low.
REQ-030 Reset mid-operation SHALL discard the in-flight transaction with no response.
REQ-031 The first grant after reset release SHALL be possible in the first cycle rst_n is high.

Verification
REQ-032 Memory pre-loaded with bytes 54..57 = 11,12,13,14: p0 word load at addr 54 -> p0_resp_valid 2 cycles after accept, p0_rdata = 0x000000000B0C0D0E, err = 0.
REQ-033 p1 double store 0x8000000000000001 at addr 8, then p1 byte load at 8 -> rdata = 0xFFFFFFFFFFFFFF80; half load at 14 -> 0x0000000000000001.
REQ-034 Both valid continuously, ARB_MODE=0 -> grants alternate p0, p1, p0, p1; ARB_MODE=1 -> p0 always, with p1 ready = 0.
REQ-035 p0 word load at addr 62 (runs past byte 63) -> no mem_read or mem_write pulse, rdata = 0, err = 1; double load at 56 -> err = 0.
REQ-036 p0_resp_ready held low 5 cycles -> resp_valid and rdata held stable; p1 valid throughout but not readied until 1 cycle after p0's response handshake.
REQ-037 rst_n low during ACCESS of a byte store 0xAA to addr 0 -> mem[0] unchanged, no resp_valid, all outputs 0 the next cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester data-memory arbiter with range checking.
// Ports: p0_*/p1_* request/response channels, mem_* memory side.
//
// Params : ARB_MODE  0 = round-robin, 1 = fixed priority (p0 wins)
//          MEM_BYTES byte size of the attached memory
// Req    : px_req_valid/ready, px_we, px_addr, px_wdata, px_size
// Resp   : px_resp_valid/ready, px_rdata, px_err
// Memory : mem_addr, mem_wdata, mem_write, mem_read, mem_size,
//          mem_rdata (combinational, big-endian, sign-extended)
module dmem_arbiter #(
  parameter int ARB_MODE  = 0,
  parameter int MEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        p0_req_valid,
  output logic        p0_req_ready,
  input  logic        p0_we,
  input  logic [63:0] p0_addr,
  input  logic [63:0] p0_wdata,
  input  logic [1:0]  p0_size,
  output logic        p0_resp_valid,
  input  logic        p0_resp_ready,
  output logic [63:0] p0_rdata,
  output logic        p0_err,

  input  logic        p1_req_valid,
  output logic        p1_req_ready,
  input  logic        p1_we,
  input  logic [63:0] p1_addr,
  input  logic [63:0] p1_wdata,
  input  logic [1:0]  p1_size,
  output logic        p1_resp_valid,
  input  logic        p1_resp_ready,
  output logic [63:0] p1_rdata,
  output logic        p1_err,

  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  output logic [1:0]  mem_size,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  typedef struct packed {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic        id;
    logic        err;
  } txn_t;

  state_e      state_q, state_d;
  logic        rr_q, rr_d;
  txn_t        txn_q, txn_d;
  logic [63:0] rdata_q, rdata_d;
  logic        rerr_q, rerr_d;

  logic        gnt;
  logic        in_idle;
  logic        in_resp;
  logic        acc_ok;
  logic        accept;
  logic        resp_hs;
  txn_t        req_sel;

  // Access runs past the end of memory or outside the 64-byte window.
  function automatic logic range_err(
    input logic [63:0] addr,
    input logic [1:0]  size
  );
    logic [7:0] end_b;
    end_b = {2'b00, addr[5:0]} + (8'd1 << size);
    return ({24'd0, end_b} > 32'(MEM_BYTES)) ||
           (addr[63:6] != '0);
  endfunction

  // gnt: 0 = p0, 1 = p1. rr_q set means p1 is favoured.
  always_comb begin
    gnt = 1'b0;
    unique case (1'b1)
      p0_req_valid && !p1_req_valid: gnt = 1'b0;
      !p0_req_valid && p1_req_valid: gnt = 1'b1;
      p0_req_valid && p1_req_valid:
        gnt = (ARB_MODE == 0) ? rr_q : 1'b0;
      default: gnt = 1'b0;
    endcase
  end

  assign in_idle = rst_n && (state_q == IDLE);
  assign in_resp = rst_n && (state_q == RESP);
  assign acc_ok  = rst_n && (state_q == ACCESS) && !txn_q.err;

  assign p0_req_ready = in_idle && p0_req_valid && !gnt;
  assign p1_req_ready = in_idle && p1_req_valid && gnt;

  assign accept = (p0_req_valid && p0_req_ready) ||
                  (p1_req_valid && p1_req_ready);

  assign resp_hs = in_resp &&
                   (txn_q.id ? p1_resp_ready : p0_resp_ready);

  always_comb begin
    req_sel       = '0;
    req_sel.id    = gnt;
    req_sel.we    = gnt ? p1_we    : p0_we;
    req_sel.addr  = gnt ? p1_addr  : p0_addr;
    req_sel.wdata = gnt ? p1_wdata : p0_wdata;
    req_sel.size  = gnt ? p1_size  : p0_size;
    req_sel.err   = range_err(req_sel.addr, req_sel.size);
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    txn_d   = txn_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = ACCESS;
          rr_d    = ~gnt;
          txn_d   = req_sel;
        end
      end
      ACCESS: begin
        state_d = RESP;
        rerr_d  = txn_q.err;
        // Stores and faulting accesses respond with zero data.
        rdata_d = (txn_q.err || txn_q.we) ? '0 : mem_rdata;
      end
      RESP: begin
        if (resp_hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      txn_q   <= '0;
      rdata_q <= '0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      txn_q   <= txn_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  // Memory strobes carry rst_n so a store cannot commit during reset.
  assign mem_read  = acc_ok && !txn_q.we;
  assign mem_write = acc_ok && txn_q.we;
  assign mem_addr  = acc_ok ? txn_q.addr  : '0;
  assign mem_wdata = acc_ok ? txn_q.wdata : '0;
  assign mem_size  = acc_ok ? txn_q.size  : '0;

  assign p0_resp_valid = in_resp && !txn_q.id;
  assign p1_resp_valid = in_resp && txn_q.id;
  assign p0_rdata = p0_resp_valid ? rdata_q : '0;
  assign p1_rdata = p1_resp_valid ? rdata_q : '0;
  assign p0_err   = p0_resp_valid && rerr_q;
  assign p1_err   = p1_resp_valid && rerr_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter.
// Big-endian sign-extending memory model; second DUT in fixed-priority mode.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        p0_req_valid, p0_we, p0_resp_ready;
  logic [63:0] p0_addr, p0_wdata;
  logic [1:0]  p0_size;
  logic        p1_req_valid, p1_we, p1_resp_ready;
  logic [63:0] p1_addr, p1_wdata;
  logic [1:0]  p1_size;

  logic        p0_req_ready, p0_resp_valid, p0_err;
  logic [63:0] p0_rdata;
  logic        p1_req_ready, p1_resp_valid, p1_err;
  logic [63:0] p1_rdata;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read;
  logic [1:0]  mem_size;

  logic        b_p0_req_ready, b_p0_resp_valid, b_p0_err;
  logic [63:0] b_p0_rdata;
  logic        b_p1_req_ready, b_p1_resp_valid, b_p1_err;
  logic [63:0] b_p1_rdata;
  logic [63:0] b_mem_addr, b_mem_wdata;
  logic        b_mem_write, b_mem_read;
  logic [1:0]  b_mem_size;

  int checks = 0;
  int failures = 0;

  // Byte i lives at memv[i*8 +: 8]; bytes 54..57 = 0B 0C 0D 0E, byte 0 = 55.
  logic [511:0] memv = (512'h0E0D0C0B << 432) | 512'h55;

  always #5 clk = ~clk;

  function automatic logic [63:0] rd_fn(
    input logic [511:0] m,
    input logic [63:0]  a,
    input logic [1:0]   s
  );
    logic [63:0] v;
    logic [5:0]  ix;
    int          n;
    v = '0;
    n = 1 << s;
    for (int i = 0; i < 8; i++) begin
      if (i < n) begin
        ix = a[5:0] + 6'(i);
        v = {v[55:0], m[int'(ix)*8 +: 8]};
      end
    end
    case (s)
      2'd0: v = {{56{v[7]}}, v[7:0]};
      2'd1: v = {{48{v[15]}}, v[15:0]};
      2'd2: v = {{32{v[31]}}, v[31:0]};
      default: v = v;
    endcase
    return v;
  endfunction

  function automatic logic [511:0] wr_fn(
    input logic [511:0] m,
    input logic [63:0]  a,
    input logic [1:0]   s,
    input logic [63:0]  d
  );
    logic [511:0] r;
    logic [5:0]   ix;
    int           n;
    r = m;
    n = 1 << s;
    for (int i = 0; i < 8; i++) begin
      if (i < n) begin
        ix = a[5:0] + 6'(i);
        r[int'(ix)*8 +: 8] = d[(n-1-i)*8 +: 8];
      end
    end
    return r;
  endfunction

  assign mem_rdata = rd_fn(memv, mem_addr, mem_size);

  always @(posedge clk) begin
    if (mem_write) memv <= wr_fn(memv, mem_addr, mem_size, mem_wdata);
  end

  dmem_arbiter #(.ARB_MODE(0), .MEM_BYTES(64)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_size(p0_size), .p0_resp_valid(p0_resp_valid),
    .p0_resp_ready(p0_resp_ready), .p0_rdata(p0_rdata),
    .p0_err(p0_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_size(p1_size), .p1_resp_valid(p1_resp_valid),
    .p1_resp_ready(p1_resp_ready), .p1_rdata(p1_rdata),
    .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_write(mem_write), .mem_read(mem_read),
    .mem_size(mem_size), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ARB_MODE(1), .MEM_BYTES(64)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .p0_req_valid(p0_req_valid), .p0_req_ready(b_p0_req_ready),
    .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_size(p0_size), .p0_resp_valid(b_p0_resp_valid),
    .p0_resp_ready(p0_resp_ready), .p0_rdata(b_p0_rdata),
    .p0_err(b_p0_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(b_p1_req_ready),
    .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_size(p1_size), .p1_resp_valid(b_p1_resp_valid),
    .p1_resp_ready(p1_resp_ready), .p1_rdata(b_p1_rdata),
    .p1_err(b_p1_err),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_write(b_mem_write), .mem_read(b_mem_read),
    .mem_size(b_mem_size), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    p0_req_valid = 1'b0; p1_req_valid = 1'b0;
    p0_addr = 64'h3; p1_addr = 64'h3;
    p0_wdata = '1; p1_wdata = '1;
    p0_size = 2'd0; p1_size = 2'd0;
    p0_we = ~p0_we; p1_we = ~p1_we;
  endtask

  // Single-requester transaction with fixed two-cycle response latency.
  task automatic txn(
    input string       tag,
    input bit          p,
    input logic        we,
    input logic [63:0] addr,
    input logic [63:0] wdata,
    input logic [1:0]  size,
    input logic [63:0] er,
    input logic        ee
  );
    if (!p) begin
      p0_req_valid = 1'b1; p0_we = we; p0_addr = addr;
      p0_wdata = wdata; p0_size = size;
    end else begin
      p1_req_valid = 1'b1; p1_we = we; p1_addr = addr;
      p1_wdata = wdata; p1_size = size;
    end
    #1;
    chk({tag, "_rdy"}, p ? p1_req_ready : p0_req_ready, 64'd1);
    chk({tag, "_nrdy"}, p ? p0_req_ready : p1_req_ready, 64'd0);
    tick();
    scramble();
    #1;
    chk({tag, "_rd"}, mem_read, 64'(!ee && !we));
    chk({tag, "_wr"}, mem_write, 64'(!ee && we));
    if (!ee) begin
      chk({tag, "_addr"}, mem_addr, addr);
      chk({tag, "_size"}, mem_size, 64'(size));
      if (we) chk({tag, "_wdata"}, mem_wdata, wdata);
    end
    chk({tag, "_early"}, p ? p1_resp_valid : p0_resp_valid, 64'd0);
    tick();
    #1;
    chk({tag, "_vld"}, p ? p1_resp_valid : p0_resp_valid, 64'd1);
    chk({tag, "_ovld"}, p ? p0_resp_valid : p1_resp_valid, 64'd0);
    chk({tag, "_rdata"}, p ? p1_rdata : p0_rdata, er);
    chk({tag, "_err"}, p ? p1_err : p0_err, 64'(ee));
    chk({tag, "_memq"}, mem_read | mem_write, 64'd0);
    tick();
  endtask

  initial begin
    p0_req_valid = 1'b1; p0_we = 1'b0; p0_addr = '0;
    p0_wdata = '0; p0_size = 2'd0; p0_resp_ready = 1'b1;
    p1_req_valid = 1'b1; p1_we = 1'b0; p1_addr = '0;
    p1_wdata = '0; p1_size = 2'd0; p1_resp_ready = 1'b1;

    rst_n = 1'b0;
    tick();
    tick();
    #1;
    chk("rst_p0rdy", p0_req_ready, 64'd0);
    chk("rst_p1rdy", p1_req_ready, 64'd0);
    chk("rst_vld", p0_resp_valid | p1_resp_valid, 64'd0);
    chk("rst_mem", mem_read | mem_write, 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    p1_req_valid = 1'b0;
    p0_req_valid = 1'b0;

    rst_n = 1'b1;
    txn("ld_w54", 1'b0, 1'b0, 64'd54, 64'd0, 2'd2,
        64'h0000_0000_0B0C_0D0E, 1'b0);
    txn("st_d8", 1'b1, 1'b1, 64'd8, 64'h8000_0000_0000_0001,
        2'd3, 64'd0, 1'b0);
    txn("ld_b8", 1'b1, 1'b0, 64'd8, 64'd0, 2'd0,
        64'hFFFF_FFFF_FFFF_FF80, 1'b0);
    txn("ld_h14", 1'b1, 1'b0, 64'd14, 64'd0, 2'd1,
        64'h0000_0000_0000_0001, 1'b0);
    txn("ld_w62", 1'b0, 1'b0, 64'd62, 64'd0, 2'd2, 64'd0, 1'b1);
    txn("ld_d56", 1'b0, 1'b0, 64'd56, 64'd0, 2'd3,
        64'h0D0E_0000_0000_0000, 1'b0);
    txn("ld_h63", 1'b1, 1'b0, 64'd63, 64'd0, 2'd1, 64'd0, 1'b1);
    txn("ld_b64", 1'b1, 1'b0, 64'd64, 64'd0, 2'd0, 64'd0, 1'b1);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    p0_req_valid = 1'b1; p0_we = 1'b0; p0_addr = 64'd0; p0_size = 2'd0;
    p1_req_valid = 1'b1; p1_we = 1'b0; p1_addr = 64'd1; p1_size = 2'd0;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_p0rdy", p0_req_ready, 64'(k % 2 == 0));
      chk("rr_p1rdy", p1_req_ready, 64'(k % 2 == 1));
      chk("fp_p0rdy", b_p0_req_ready, 64'd1);
      chk("fp_p1rdy", b_p1_req_ready, 64'd0);
      tick();
      tick();
      #1;
      chk("rr_vld", p1_resp_valid, 64'(k % 2));
      chk("fp_vld", b_p0_resp_valid, 64'd1);
      chk("rr_busy", p0_req_ready | p1_req_ready, 64'd0);
      tick();
    end

    p0_addr = 64'd54; p0_size = 2'd2; p0_resp_ready = 1'b0;
    p1_addr = 64'd8;
    #1;
    chk("hold_p0rdy", p0_req_ready, 64'd1);
    chk("hold_p1rdy0", p1_req_ready, 64'd0);
    tick();
    p0_req_valid = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("hold_vld", p0_resp_valid, 64'd1);
      chk("hold_data", p0_rdata, 64'h0000_0000_0B0C_0D0E);
      chk("hold_p1rdy", p1_req_ready, 64'd0);
      tick();
    end
    p0_resp_ready = 1'b1;
    #1;
    chk("hs_vld", p0_resp_valid, 64'd1);
    chk("hs_p1rdy", p1_req_ready, 64'd0);
    tick();
    #1;
    chk("post_vld", p0_resp_valid, 64'd0);
    chk("post_p1rdy", p1_req_ready, 64'd1);
    tick();
    p1_req_valid = 1'b0;
    tick();
    #1;
    chk("p1_vld", p1_resp_valid, 64'd1);
    chk("p1_data", p1_rdata, 64'hFFFF_FFFF_FFFF_FF80);
    tick();

    p0_req_valid = 1'b1; p0_we = 1'b1; p0_addr = 64'd0;
    p0_wdata = 64'hAA; p0_size = 2'd0;
    #1;
    chk("ab_rdy", p0_req_ready, 64'd1);
    tick();
    p0_req_valid = 1'b0;
    #1;
    chk("ab_wr", mem_write, 64'd1);
    rst_n = 1'b0;
    #1;
    chk("ab_wr_gated", mem_write | mem_read, 64'd0);
    chk("ab_addr", mem_addr, 64'd0);
    tick();
    #1;
    chk("ab_mem0", 64'(memv[7:0]), 64'h55);
    chk("ab_vld", p0_resp_valid | p1_resp_valid, 64'd0);
    chk("ab_rdata", p0_rdata | p1_rdata, 64'd0);
    chk("ab_err", p0_err | p1_err, 64'd0);
    chk("ab_rdy0", p0_req_ready | p1_req_ready, 64'd0);
    rst_n = 1'b1;
    tick();
    #1;
    chk("ab_norsp", p0_resp_valid, 64'd0);
    chk("ab_mem0b", 64'(memv[7:0]), 64'h55);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
